// File: rtl/dma_pkg.sv
// Shared register map and write-target decode for the 8237-style register access decoder.
// DMA_MASK_DECODE_EN adds decode of the request/mask register writes (0x9, 0xA, 0xE, 0xF).
package dma_pkg;

   localparam int ADDR_W = 4;

   localparam logic [ADDR_W-1:0] ADDR_CMD_STATUS  = 4'h8;
   localparam logic [ADDR_W-1:0] ADDR_REQUEST     = 4'h9;
   localparam logic [ADDR_W-1:0] ADDR_SINGLE_MASK = 4'hA;
   localparam logic [ADDR_W-1:0] ADDR_MODE        = 4'hB;
   localparam logic [ADDR_W-1:0] ADDR_CLR_FF      = 4'hC;
   localparam logic [ADDR_W-1:0] ADDR_MASTER_CLR  = 4'hD;
   localparam logic [ADDR_W-1:0] ADDR_CLR_MASK    = 4'hE;
   localparam logic [ADDR_W-1:0] ADDR_ALL_MASK    = 4'hF;

   typedef enum logic [3:0] {
      WR_NONE,
      WR_BASE_ADDR,
      WR_BASE_WC,
      WR_CMD,
      WR_MODE,
      WR_CLR_FF,
      WR_MASTER_CLR,
      WR_REQUEST,
      WR_SINGLE_MASK,
      WR_CLR_MASK,
      WR_ALL_MASK
   } wr_target_e;

   // Channel registers occupy 0x0-0x7: even = address, odd = word count.
   function automatic wr_target_e decode_write(input logic [ADDR_W-1:0] addr);
      wr_target_e t;
      t = WR_NONE;
      if (!addr[3]) begin
         t = addr[0] ? WR_BASE_WC : WR_BASE_ADDR;
      end else begin
         case (addr)
            ADDR_CMD_STATUS:  t = WR_CMD;
            ADDR_MODE:        t = WR_MODE;
            ADDR_CLR_FF:      t = WR_CLR_FF;
            ADDR_MASTER_CLR:  t = WR_MASTER_CLR;
`ifdef DMA_MASK_DECODE_EN
            ADDR_REQUEST:     t = WR_REQUEST;
            ADDR_SINGLE_MASK: t = WR_SINGLE_MASK;
            ADDR_CLR_MASK:    t = WR_CLR_MASK;
            ADDR_ALL_MASK:    t = WR_ALL_MASK;
`else
            ADDR_REQUEST, ADDR_SINGLE_MASK,
            ADDR_CLR_MASK, ADDR_ALL_MASK: t = WR_NONE;
`endif
            default:          t = WR_NONE;
         endcase
      end
      return t;
   endfunction

endpackage

// File: rtl/dma_reg_access_decoder_if.sv
// CPU-side bus inputs and datapath strobes of the register access decoder.
// DMA_MASK_DECODE_EN adds the four mask/request load strobes.
interface dma_reg_access_decoder_if;
   import dma_pkg::*;

   logic              CS_N;
   logic              IOR_N;
   logic              IOW_N;
   logic [ADDR_W-1:0] A;
   logic              programCondition;

   logic              loadIoDataBufferFromDB;
   logic              loadIoDataBufferFromStatus;
   logic              readStatusReg;
   logic              readCurrentAddressReg;
   logic              readCurrentWordCountReg;
   logic              loadCommandReg;
   logic              loadModeReg;
   logic              loadBaseAddressReg;
   logic              loadBaseWordCountReg;
   logic              clearInternalFF;
   logic              masterClear;
   logic [1:0]        channelSel;
   logic              upperByte;
   logic              internalFF;
`ifdef DMA_MASK_DECODE_EN
   logic              loadRequestReg;
   logic              loadSingleMask;
   logic              clearMaskReg;
   logic              loadAllMask;

   modport slave (
      input  CS_N, IOR_N, IOW_N, A, programCondition,
      output loadIoDataBufferFromDB, loadIoDataBufferFromStatus, readStatusReg,
             readCurrentAddressReg, readCurrentWordCountReg, loadCommandReg,
             loadModeReg, loadBaseAddressReg, loadBaseWordCountReg,
             clearInternalFF, masterClear, channelSel, upperByte, internalFF,
             loadRequestReg, loadSingleMask, clearMaskReg, loadAllMask
   );
   modport master (
      output CS_N, IOR_N, IOW_N, A, programCondition,
      input  loadIoDataBufferFromDB, loadIoDataBufferFromStatus, readStatusReg,
             readCurrentAddressReg, readCurrentWordCountReg, loadCommandReg,
             loadModeReg, loadBaseAddressReg, loadBaseWordCountReg,
             clearInternalFF, masterClear, channelSel, upperByte, internalFF,
             loadRequestReg, loadSingleMask, clearMaskReg, loadAllMask
   );
`else
   modport slave (
      input  CS_N, IOR_N, IOW_N, A, programCondition,
      output loadIoDataBufferFromDB, loadIoDataBufferFromStatus, readStatusReg,
             readCurrentAddressReg, readCurrentWordCountReg, loadCommandReg,
             loadModeReg, loadBaseAddressReg, loadBaseWordCountReg,
             clearInternalFF, masterClear, channelSel, upperByte, internalFF
   );
   modport master (
      output CS_N, IOR_N, IOW_N, A, programCondition,
      input  loadIoDataBufferFromDB, loadIoDataBufferFromStatus, readStatusReg,
             readCurrentAddressReg, readCurrentWordCountReg, loadCommandReg,
             loadModeReg, loadBaseAddressReg, loadBaseWordCountReg,
             clearInternalFF, masterClear, channelSel, upperByte, internalFF
   );
`endif

endinterface

// File: rtl/dma_byte_pointer.sv
// Byte-pointer (internal) flip-flop: toggles per channel-register access, clear has priority.
module dma_byte_pointer (
   input  logic CLK,
   input  logic RESET_N,
   input  logic toggle,
   input  logic clear,
   output logic ff
);

   logic ff_q, ff_d;

   always_comb begin
      ff_d = ff_q;
      if (toggle) ff_d = ~ff_q;
      if (clear)  ff_d = 1'b0;
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) ff_q <= 1'b0;
      else          ff_q <= ff_d;
   end

   assign ff = ff_q;

endmodule

// File: rtl/dma_reg_access_decoder.sv
// 8237 program-mode register access decoder: read strobes in the access cycle, load strobes one cycle later.
// DMA_MASK_DECODE_EN enables the request/mask register load strobes.
module dma_reg_access_decoder
   import dma_pkg::*;
(
   input  logic                    CLK,
   input  logic                    RESET_N,
   dma_reg_access_decoder_if.slave bus
);

   logic       ior_q, ior_d, iow_q, iow_d;
   logic       rd_arm_q, rd_arm_d, wr_arm_q, wr_arm_d;
   wr_target_e wr_tgt_q, wr_tgt_d;
   logic [1:0] chan_q, chan_d;
   logic       upper_q, upper_d;

   logic       qual, acc_rd, acc_wr, low_reg, rd_low;
   logic       toggle_ff, clr_ff, ff;

   // The arm flags keep a strobe held low across reset release from counting as a fresh edge.
   always_comb begin
      qual      = bus.programCondition & ~bus.CS_N;
      acc_rd    = qual & ~bus.IOR_N & bus.IOW_N & ior_q & rd_arm_q;
      acc_wr    = qual & ~bus.IOW_N & bus.IOR_N & iow_q & wr_arm_q;
      low_reg   = ~bus.A[3];
      rd_low    = acc_rd & low_reg;
      toggle_ff = (acc_rd | acc_wr) & low_reg;

      ior_d     = bus.IOR_N;
      iow_d     = bus.IOW_N;
      rd_arm_d  = rd_arm_q | bus.IOR_N;
      wr_arm_d  = wr_arm_q | bus.IOW_N;
      wr_tgt_d  = acc_wr ? decode_write(bus.A) : WR_NONE;
      chan_d    = (acc_wr & low_reg) ? bus.A[2:1] : 2'b00;
      upper_d   = acc_wr & low_reg & ff;
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         ior_q    <= 1'b1;
         iow_q    <= 1'b1;
         rd_arm_q <= 1'b0;
         wr_arm_q <= 1'b0;
         wr_tgt_q <= WR_NONE;
         chan_q   <= 2'b00;
         upper_q  <= 1'b0;
      end else begin
         ior_q    <= ior_d;
         iow_q    <= iow_d;
         rd_arm_q <= rd_arm_d;
         wr_arm_q <= wr_arm_d;
         wr_tgt_q <= wr_tgt_d;
         chan_q   <= chan_d;
         upper_q  <= upper_d;
      end
   end

   assign clr_ff = (wr_tgt_q == WR_CLR_FF) || (wr_tgt_q == WR_MASTER_CLR);

   dma_byte_pointer u_byte_pointer (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .toggle  (toggle_ff),
      .clear   (clr_ff),
      .ff      (ff)
   );

   assign bus.loadIoDataBufferFromDB     = acc_wr;
   assign bus.loadIoDataBufferFromStatus = acc_rd & (bus.A == ADDR_CMD_STATUS);
   assign bus.readStatusReg              = acc_rd & (bus.A == ADDR_CMD_STATUS);
   assign bus.readCurrentAddressReg      = rd_low & ~bus.A[0];
   assign bus.readCurrentWordCountReg    = rd_low & bus.A[0];
   assign bus.loadCommandReg             = (wr_tgt_q == WR_CMD);
   assign bus.loadModeReg                = (wr_tgt_q == WR_MODE);
   assign bus.loadBaseAddressReg         = (wr_tgt_q == WR_BASE_ADDR);
   assign bus.loadBaseWordCountReg       = (wr_tgt_q == WR_BASE_WC);
   assign bus.clearInternalFF            = clr_ff;
   assign bus.masterClear                = (wr_tgt_q == WR_MASTER_CLR);
   // Reads are combinational, so a read sharing a cycle with a pending write strobe owns these.
   assign bus.channelSel                 = rd_low ? bus.A[2:1] : chan_q;
   assign bus.upperByte                  = rd_low ? ff : upper_q;
   assign bus.internalFF                 = ff;
`ifdef DMA_MASK_DECODE_EN
   assign bus.loadRequestReg             = (wr_tgt_q == WR_REQUEST);
   assign bus.loadSingleMask             = (wr_tgt_q == WR_SINGLE_MASK);
   assign bus.clearMaskReg               = (wr_tgt_q == WR_CLR_MASK);
   assign bus.loadAllMask                = (wr_tgt_q == WR_ALL_MASK);
`endif

endmodule

// File: tb/tb_dma_reg_access_decoder.sv
// Bench for dma_reg_access_decoder: directed scenarios plus random traffic against a per-cycle reference model.
module tb_dma_reg_access_decoder;
   import dma_pkg::*;

   localparam logic [14:0] S_LDDB    = 15'h0001;
   localparam logic [14:0] S_LDST    = 15'h0002;
   localparam logic [14:0] S_RDST    = 15'h0004;
   localparam logic [14:0] S_RDBA    = 15'h0008;
   localparam logic [14:0] S_RDWC    = 15'h0010;
   localparam logic [14:0] S_LDCMD   = 15'h0020;
   localparam logic [14:0] S_LDMODE  = 15'h0040;
   localparam logic [14:0] S_LDBA    = 15'h0080;
   localparam logic [14:0] S_LDBWC   = 15'h0100;
   localparam logic [14:0] S_CLRFF   = 15'h0200;
   localparam logic [14:0] S_MCLR    = 15'h0400;
   localparam logic [14:0] S_REQ     = 15'h0800;
   localparam logic [14:0] S_SMASK   = 15'h1000;
   localparam logic [14:0] S_CLRMASK = 15'h2000;
   localparam logic [14:0] S_ALLMASK = 15'h4000;

   logic CLK = 1'b0;
   logic RESET_N;
   always #5 CLK = ~CLK;

   dma_reg_access_decoder_if bus();

   dma_reg_access_decoder dut (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .bus     (bus)
   );

   int checks = 0;
   int failures = 0;

   // reference model state
   bit          m_ff;
   logic [14:0] m_pend;
   bit          m_pend_low;
   logic [1:0]  m_pend_chan;
   bit          m_pend_upper;
   bit          m_prev_r, m_prev_w;

   // expectations for the current cycle
   logic [14:0] exp_vec;
   bit          exp_cu;
   logic [1:0]  exp_chan;
   bit          exp_upper;
   bit          exp_ff;

   function automatic logic [14:0] act_vec();
      logic [14:0] v;
      v = '0;
      v[0]  = bus.loadIoDataBufferFromDB;
      v[1]  = bus.loadIoDataBufferFromStatus;
      v[2]  = bus.readStatusReg;
      v[3]  = bus.readCurrentAddressReg;
      v[4]  = bus.readCurrentWordCountReg;
      v[5]  = bus.loadCommandReg;
      v[6]  = bus.loadModeReg;
      v[7]  = bus.loadBaseAddressReg;
      v[8]  = bus.loadBaseWordCountReg;
      v[9]  = bus.clearInternalFF;
      v[10] = bus.masterClear;
`ifdef DMA_MASK_DECODE_EN
      v[11] = bus.loadRequestReg;
      v[12] = bus.loadSingleMask;
      v[13] = bus.clearMaskReg;
      v[14] = bus.loadAllMask;
`endif
      return v;
   endfunction

   function automatic logic [14:0] write_effect(input int a);
      logic [14:0] v;
      v = '0;
      if (a < 8) v = (a % 2 != 0) ? S_LDBWC : S_LDBA;
      else begin
         case (a)
            8:  v = S_LDCMD;
            11: v = S_LDMODE;
            12: v = S_CLRFF;
            13: v = S_MCLR | S_CLRFF;
`ifdef DMA_MASK_DECODE_EN
            9:  v = S_REQ;
            10: v = S_SMASK;
            14: v = S_CLRMASK;
            15: v = S_ALLMASK;
`endif
            default: v = '0;
         endcase
      end
      return v;
   endfunction

   task automatic model_reset();
      m_ff = 0; m_pend = '0; m_pend_low = 0; m_pend_chan = 2'b00; m_pend_upper = 0;
      m_prev_r = 0; m_prev_w = 0;
   endtask

   // Drive one cycle's inputs, then derive what this cycle must show and what the clock edge leaves behind.
   task automatic step(input bit pc, input bit cs_n, input bit ior_n, input bit iow_n, input int a);
      bit q, rd, wr, clear, toggle;
      @(negedge CLK);
      bus.programCondition = pc;
      bus.CS_N  = cs_n;
      bus.IOR_N = ior_n;
      bus.IOW_N = iow_n;
      bus.A     = 4'(a);
      #1;
      q  = pc && !cs_n;
      rd = q && !ior_n && iow_n && m_prev_r;
      wr = q && !iow_n && ior_n && m_prev_w;
      exp_vec = m_pend; exp_cu = m_pend_low; exp_chan = m_pend_chan; exp_upper = m_pend_upper;
      exp_ff = m_ff;
      if (wr) exp_vec = exp_vec | S_LDDB;
      if (rd) begin
         if (a == 8) exp_vec = exp_vec | S_LDST | S_RDST;
         else if (a < 8) begin
            exp_vec = exp_vec | ((a % 2 != 0) ? S_RDWC : S_RDBA);
            exp_cu = 1; exp_chan = 2'((a >> 1) & 3); exp_upper = m_ff;
         end
      end
      clear  = (m_pend & S_CLRFF) != '0;
      toggle = (rd || wr) && a < 8;
      m_pend       = wr ? write_effect(a) : '0;
      m_pend_low   = wr && a < 8;
      m_pend_chan  = (wr && a < 8) ? 2'((a >> 1) & 3) : 2'b00;
      m_pend_upper = wr && a < 8 && m_ff;
      if (clear)       m_ff = 0;
      else if (toggle) m_ff = !m_ff;
      m_prev_r = ior_n;
      m_prev_w = iow_n;
   endtask

   task automatic test_reset();
      bus.programCondition = 1; bus.CS_N = 0; bus.IOR_N = 1; bus.IOW_N = 0; bus.A = 4'h8;
      RESET_N = 1;
      #2 RESET_N = 0;
      model_reset();
      repeat (2) @(posedge CLK);
      #1;
      checks++;
      if (act_vec() !== '0) begin failures++; $display("FAIL reset_strobes got=%h exp=0", act_vec()); end
      checks++;
      if (bus.internalFF !== 1'b0 || bus.channelSel !== 2'b00 || bus.upperByte !== 1'b0) begin
         failures++; $display("FAIL reset_state ff=%b chan=%0d upper=%b exp=0", bus.internalFF, bus.channelSel, bus.upperByte);
      end
      @(negedge CLK);
      RESET_N = 1;
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 1, 0, 8);
         checks++;
         if (act_vec() !== '0) begin failures++; $display("FAIL reset_held_iow cyc=%0d got=%h exp=0", i, act_vec()); end
      end
      step(1, 0, 1, 1, 8);
      checks++;
      if (act_vec() !== '0) begin failures++; $display("FAIL reset_release_idle got=%h exp=0", act_vec()); end
   endtask

   task automatic test_command_write();
      step(1, 0, 1, 1, 8);
      step(1, 0, 1, 0, 8);
      checks++;
      if (act_vec() !== S_LDDB) begin failures++; $display("FAIL cmd_write_T got=%h exp=%h", act_vec(), S_LDDB); end
      step(1, 0, 1, 0, 8);
      checks++;
      if (act_vec() !== S_LDCMD) begin failures++; $display("FAIL cmd_write_T1 got=%h exp=%h", act_vec(), S_LDCMD); end
      step(1, 0, 1, 1, 8);
      checks++;
      if (act_vec() !== '0) begin failures++; $display("FAIL cmd_write_T2 got=%h exp=0", act_vec()); end
   endtask

   task automatic test_status_read();
      step(1, 0, 0, 1, 8);
      checks++;
      if (act_vec() !== (S_LDST | S_RDST)) begin failures++; $display("FAIL status_read_T got=%h exp=%h", act_vec(), S_LDST | S_RDST); end
      step(1, 0, 0, 1, 8);
      checks++;
      if (act_vec() !== '0) begin failures++; $display("FAIL status_read_held got=%h exp=0", act_vec()); end
      step(1, 0, 1, 1, 8);
   endtask

   task automatic test_byte_pointer();
      step(1, 0, 1, 0, 2);
      checks++;
      if (act_vec() !== S_LDDB) begin failures++; $display("FAIL bp_write1_T got=%h exp=%h", act_vec(), S_LDDB); end
      step(1, 0, 1, 1, 2);
      checks++;
      if (act_vec() !== S_LDBA || bus.channelSel !== 2'd1 || bus.upperByte !== 1'b0 || bus.internalFF !== 1'b1) begin
         failures++; $display("FAIL bp_write1_T1 got=%h/%0d/%b/%b exp=%h/1/0/1", act_vec(), bus.channelSel, bus.upperByte, bus.internalFF, S_LDBA);
      end
      step(1, 0, 1, 0, 2);
      step(1, 0, 1, 1, 2);
      checks++;
      if (act_vec() !== S_LDBA || bus.channelSel !== 2'd1 || bus.upperByte !== 1'b1 || bus.internalFF !== 1'b0) begin
         failures++; $display("FAIL bp_write2_T1 got=%h/%0d/%b/%b exp=%h/1/1/0", act_vec(), bus.channelSel, bus.upperByte, bus.internalFF, S_LDBA);
      end
      step(1, 0, 1, 0, 12);
      step(1, 0, 1, 1, 12);
      checks++;
      if (act_vec() !== S_CLRFF) begin failures++; $display("FAIL bp_clear_T1 got=%h exp=%h", act_vec(), S_CLRFF); end
      // clear-ff pending while a channel read would toggle the pointer from 0 to 1
      step(1, 0, 1, 0, 12);
      step(1, 0, 0, 1, 0);
      checks++;
      if (act_vec() !== (S_CLRFF | S_RDBA) || bus.upperByte !== 1'b0 || bus.channelSel !== 2'd0) begin
         failures++; $display("FAIL bp_clear_read got=%h/%b exp=%h/0", act_vec(), bus.upperByte, S_CLRFF | S_RDBA);
      end
      step(1, 0, 1, 1, 0);
      checks++;
      if (bus.internalFF !== 1'b0) begin failures++; $display("FAIL bp_clear_wins got=%b exp=0", bus.internalFF); end
      step(1, 0, 1, 0, 3);
      step(1, 0, 1, 1, 3);
      checks++;
      if (act_vec() !== S_LDBWC || bus.channelSel !== 2'd1 || bus.internalFF !== 1'b1) begin
         failures++; $display("FAIL bp_wc_write got=%h/%0d/%b exp=%h/1/1", act_vec(), bus.channelSel, bus.internalFF, S_LDBWC);
      end
      step(1, 0, 1, 0, 13);
      step(1, 0, 1, 1, 13);
      checks++;
      if (act_vec() !== (S_MCLR | S_CLRFF)) begin failures++; $display("FAIL bp_master_clear got=%h exp=%h", act_vec(), S_MCLR | S_CLRFF); end
      step(1, 0, 1, 1, 13);
      checks++;
      if (act_vec() !== '0 || bus.internalFF !== 1'b0) begin failures++; $display("FAIL bp_after_mclr got=%h/%b exp=0/0", act_vec(), bus.internalFF); end
   endtask

   task automatic test_qualification();
      step(1, 0, 0, 0, 8);
      checks++;
      if (act_vec() !== '0) begin failures++; $display("FAIL qual_both_low got=%h exp=0", act_vec()); end
      step(1, 0, 1, 0, 8);
      checks++;
      if (act_vec() !== '0) begin failures++; $display("FAIL qual_after_both_low got=%h exp=0", act_vec()); end
      step(1, 0, 1, 1, 2);
      step(0, 0, 1, 0, 2);
      checks++;
      if (act_vec() !== '0) begin failures++; $display("FAIL qual_no_program got=%h exp=0", act_vec()); end
      step(0, 0, 1, 1, 2);
      step(1, 1, 1, 0, 2);
      checks++;
      if (act_vec() !== '0) begin failures++; $display("FAIL qual_cs_high_wr got=%h exp=0", act_vec()); end
      step(1, 1, 0, 1, 2);
      checks++;
      if (act_vec() !== '0) begin failures++; $display("FAIL qual_cs_high_rd got=%h exp=0", act_vec()); end
      step(1, 1, 1, 1, 2);
      checks++;
      if (act_vec() !== '0 || bus.internalFF !== 1'b0) begin failures++; $display("FAIL qual_ff_hold got=%h/%b exp=0/0", act_vec(), bus.internalFF); end
   endtask

   task automatic test_mask_decode();
      logic [14:0] exp_t1;
`ifdef DMA_MASK_DECODE_EN
      exp_t1 = S_ALLMASK;
`else
      exp_t1 = '0;
`endif
      step(1, 0, 1, 1, 15);
      step(1, 0, 1, 0, 15);
      checks++;
      if (act_vec() !== S_LDDB) begin failures++; $display("FAIL mask_write_T got=%h exp=%h", act_vec(), S_LDDB); end
      step(1, 0, 1, 1, 15);
      checks++;
      if (act_vec() !== exp_t1) begin failures++; $display("FAIL mask_write_T1 got=%h exp=%h", act_vec(), exp_t1); end
   endtask

   task automatic test_random();
      int r;
      bit pc, cs_n, ior_n, iow_n;
      for (int i = 0; i < 400; i++) begin
         pc   = $urandom_range(0, 7) != 0;
         cs_n = $urandom_range(0, 7) == 0;
         r    = $urandom_range(0, 9);
         ior_n = !(r == 7 || r == 8 || r == 9);
         iow_n = !(r == 4 || r == 5 || r == 6 || r == 9);
         step(pc, cs_n, ior_n, iow_n, int'($urandom_range(0, 15)));
         checks++;
         if (act_vec() !== exp_vec) begin failures++; $display("FAIL rand_strobes cyc=%0d got=%h exp=%h", i, act_vec(), exp_vec); end
         checks++;
         if (bus.internalFF !== exp_ff) begin failures++; $display("FAIL rand_ff cyc=%0d got=%b exp=%b", i, bus.internalFF, exp_ff); end
         if (exp_cu) begin
            checks++;
            if (bus.channelSel !== exp_chan || bus.upperByte !== exp_upper) begin
               failures++; $display("FAIL rand_chan_upper cyc=%0d got=%0d/%b exp=%0d/%b", i, bus.channelSel, bus.upperByte, exp_chan, exp_upper);
            end
         end
      end
   endtask

   task automatic test_reset_mid_access();
      step(1, 0, 1, 1, 8);
      step(1, 0, 1, 0, 8);
      checks++;
      if (act_vec() !== S_LDDB) begin failures++; $display("FAIL mid_reset_T got=%h exp=%h", act_vec(), S_LDDB); end
      @(posedge CLK);
      #1;
      checks++;
      if (bus.loadCommandReg !== 1'b1) begin failures++; $display("FAIL mid_reset_pending got=%b exp=1", bus.loadCommandReg); end
      RESET_N = 0;
      model_reset();
      #1;
      checks++;
      if (act_vec() !== '0) begin failures++; $display("FAIL mid_reset_drop got=%h exp=0", act_vec()); end
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RESET_N = 1;
      for (int i = 0; i < 2; i++) begin
         step(1, 0, 1, 0, 8);
         checks++;
         if (act_vec() !== '0) begin failures++; $display("FAIL mid_reset_held cyc=%0d got=%h exp=0", i, act_vec()); end
      end
      step(1, 0, 1, 1, 8);
      step(1, 0, 1, 0, 8);
      checks++;
      if (act_vec() !== S_LDDB) begin failures++; $display("FAIL mid_reset_rearm got=%h exp=%h", act_vec(), S_LDDB); end
      step(1, 0, 1, 1, 8);
      checks++;
      if (act_vec() !== S_LDCMD) begin failures++; $display("FAIL mid_reset_rearm_T1 got=%h exp=%h", act_vec(), S_LDCMD); end
   endtask

   initial begin
      test_reset();
      test_command_write();
      test_status_read();
      test_byte_pointer();
      test_qualification();
      test_mask_decode();
      test_random();
      test_reset_mid_access();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dma_reg_access_decoder.md
Name: dma_reg_access_decoder

Overview:
- Cycle-level reference model of the 8237-style DMA controller's CPU-side register-access decode, in program (slave) mode.
- Watches CS_N, IOR_N, IOW_N, A[3:0] and programCondition, and emits the one-cycle strobes the datapath must produce: I/O data buffer loads, register loads and register reads.
- Also keeps an independent copy of the byte-pointer (internal) flip-flop.
- Instantiated beside the DMA controller so property checkers can compare its strobes against the real datapath.

Parameters:
- ADDR_W, 4, number of decoded low address bits (A3..A0); fixed for the 8237 map.

Ports:
- CLK  in  1  rising-edge clock
- RESET_N  in  1  asynchronous active-low reset
- CS_N  in  1  chip select, active low
- IOR_N  in  1  I/O read strobe, active low
- IOW_N  in  1  I/O write strobe, active low
- A  in  4  register address A3..A0
- programCondition  in  1  controller is in program mode (idle, no HLDA)
- loadIoDataBufferFromDB  out  1  latch DB into the I/O data buffer
- loadIoDataBufferFromStatus  out  1  latch the status register into the I/O data buffer
- readStatusReg  out  1  status register read
- readCurrentAddressReg  out  1  current address register read
- readCurrentWordCountReg  out  1  current word count register read
- loadCommandReg  out  1  command register load
- loadModeReg  out  1  mode register load
- loadBaseAddressReg  out  1  base and current address register load
- loadBaseWordCountReg  out  1  base and current word count register load
- clearInternalFF  out  1  byte-pointer clear
- masterClear  out  1  master clear
- channelSel  out  2  channel addressed (A2:A1), valid with any strobe
- upperByte  out  1  byte pointer value at access time (0 = low byte)
- internalFF  out  1  current byte-pointer state

Behaviour:
- Access qualify: access = programCondition & !CS_N & exactly one of IOR_N/IOW_N low.
- Edge detect: an access is recognised only on its first cycle, i.e. the selected strobe was high in the previous cycle (registered copies of IOR_N and IOW_N). Holding a strobe low produces no further pulses.
- IOR_N and IOW_N both low: invalid, no outputs, no state change. programCondition low or CS_N high: no outputs, byte pointer holds.
- Write access recognised in cycle T:
  - loadIoDataBufferFromDB=1 combinationally in T.
  - Decoded load strobe is registered and is high for exactly cycle T+1:
    - A=0x0/2/4/6 -> loadBaseAddressReg
    - A=0x1/3/5/7 -> loadBaseWordCountReg
    - A=0x8 -> loadCommandReg
    - A=0xB -> loadModeReg
    - A=0xC -> clearInternalFF
    - A=0xD -> masterClear and clearInternalFF
    - A=0x9, 0xA, 0xE, 0xF -> no strobe unless the optional feature is enabled.
- Read access recognised in cycle T, combinational in T:
  - A=0x8 -> readStatusReg and loadIoDataBufferFromStatus
  - A=0x0/2/4/6 -> readCurrentAddressReg
  - A=0x1/3/5/7 -> readCurrentWordCountReg
  - other addresses -> no strobe
- channelSel: A[2:1] for accesses to 0x0-0x7.
- channelSel and upperByte timing: both are registered with write strobes and valid in T+1; for reads they are combinational and valid in T.
- Byte pointer update:
  - internalFF toggles at the clock edge ending T for any read or write access to 0x0-0x7.
  - It is cleared at the edge ending the cycle in which clearInternalFF is high.
  - If clear and toggle coincide, clear wins.
- Reset: RESET_N low asynchronously clears all outputs, internalFF and the pipeline registers. Registered strobe copies reset to 1 (inactive).
- Reset mid-access: any pending T+1 strobe is dropped; after release a strobe still held low does not generate an access until it goes high then low.

Optional Feature:
- Macro DMA_MASK_DECODE_EN.
- Defined: four extra output ports, loadRequestReg (A=0x9), loadSingleMask (A=0xA), clearMaskReg (A=0xE), loadAllMask (A=0xF). Write-only; same T+1 timing as the other load strobes.
- Undefined: those ports are absent and writes to those addresses produce only loadIoDataBufferFromDB.

Decomposition:
- Shared package dma_pkg: register address localparams (ADDR_CMD_STATUS=4'h8, ADDR_REQUEST=4'h9, ADDR_SINGLE_MASK=4'hA, ADDR_MODE=4'hB, ADDR_CLR_FF=4'hC, ADDR_MASTER_CLR=4'hD, ADDR_CLR_MASK=4'hE, ADDR_ALL_MASK=4'hF) and a typedef enum for the decoded write target.
- No sub-module needed. The byte-pointer flip-flop may be a small sub-module, dma_byte_pointer, if reuse is wanted.

Test Plan:
- Reset: RESET_N=0 -> all outputs 0, internalFF=0; release while IOW_N held low -> no strobes.
- Command write: programCondition=1, CS_N=0, A=0x8, IOW_N low 2 cycles -> loadIoDataBufferFromDB in T only, loadCommandReg in T+1 only.
- Status read: A=0x8, IOR_N low -> readStatusReg and loadIoDataBufferFromStatus high in T only.
- Byte pointer: two writes to A=0x2 -> loadBaseAddressReg twice with channelSel=1, upperByte 0 then 1; internalFF ends at 0. Then write A=0xC -> clearInternalFF in T+1.
- Qualification: IOR_N=IOW_N=0, or programCondition=0, or CS_N=1 with A=0x8 -> no strobes, internalFF unchanged.
- Mask decode: with DMA_MASK_DECODE_EN, write A=0xF -> loadAllMask in T+1. Without the macro, the same write gives only loadIoDataBufferFromDB.
